// File: rtl/mii_frame_checker.sv
// mii_frame_checker: parses idle/start/preamble/SFD/data/terminate byte streams,
// forwards payload, checks framing and pattern, reports per-frame results and stats.
module mii_frame_checker #(
  parameter int         PREAMBLE_MIN      = 6,
  parameter int         PREAMBLE_MAX      = 7,
  parameter int         DATA_MIN          = 46,
  parameter int         DATA_MAX          = 1500,
  parameter bit         CHECK_PATTERN     = 1'b1,
  parameter logic [7:0] DATA_CHAR_PATTERN = 8'hAA,
  parameter logic [7:0] IDLE_CODE         = 8'h07,
  parameter logic [7:0] START_CODE        = 8'hFB,
  parameter logic [7:0] PREAMBLE_CODE     = 8'h55,
  parameter logic [7:0] SFD_CODE          = 8'hD5,
  parameter logic [7:0] TERMINATE_CODE    = 8'hFD
) (
  input  logic        tx_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_ctrl,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [2:0]  o_err_code,
  output logic [10:0] o_byte_count,
  output logic [15:0] o_good_frames,
  output logic [15:0] o_bad_frames
);
  localparam int PW = $clog2(PREAMBLE_MAX + 2);
  localparam logic [2:0] E_PRE_SHORT = 3'd1, E_PRE_LONG = 3'd2, E_BAD_PRE = 3'd3,
                         E_TOO_SHORT = 3'd4, E_TOO_LONG = 3'd5, E_PATTERN = 3'd6, E_BAD_CTRL = 3'd7;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d, pre_inc;
  logic [10:0]   cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic          pat_q, pat_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d, sof_q, sof_d, eof_q, eof_d, ok_q, ok_d, err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic [15:0]   good_q, good_d, bad_q, bad_d;
  logic          is_ctl, is_dat;
  assign pre_inc = pre_q + PW'(1);
  assign is_ctl  = i_rx_ctrl;
  assign is_dat  = !i_rx_ctrl;
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    bcnt_d  = bcnt_q;
    unique case (state_q)
      IDLE: begin
        if (is_ctl && i_rx_data == START_CODE) begin
          state_d = PREAMBLE;
          pre_d   = '0;
        end else if (is_dat && i_rx_data == PREAMBLE_CODE) begin
          state_d = PREAMBLE;
          pre_d   = PW'(1);
        end
      end
      PREAMBLE: begin
        if (is_dat && i_rx_data == PREAMBLE_CODE) begin
          pre_d = pre_inc;
          if (pre_inc > PW'(PREAMBLE_MAX)) begin
            err_d   = 1'b1;
            code_d  = E_PRE_LONG;
            state_d = DROP;
          end
        end else if (is_dat && i_rx_data == SFD_CODE) begin
          if (pre_q >= PW'(PREAMBLE_MIN)) begin
            state_d = DATA;
            cnt_d   = '0;
            pat_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
            code_d  = E_PRE_SHORT;
            state_d = DROP;
          end
        end else begin
          err_d   = 1'b1;
          code_d  = E_BAD_PRE;
          state_d = (is_ctl && i_rx_data == IDLE_CODE) ? IDLE : DROP;
        end
      end
      DATA: begin
        if (is_dat) begin
          if (cnt_q == 11'(DATA_MAX)) begin
            err_d   = 1'b1;
            code_d  = E_TOO_LONG;
            state_d = DROP;
          end else begin
            data_d = i_rx_data;
            dv_d   = 1'b1;
            sof_d  = cnt_q == '0;
            cnt_d  = cnt_q + 11'd1;
            pat_d  = pat_q | (CHECK_PATTERN && i_rx_data != DATA_CHAR_PATTERN);
          end
        end else if (i_rx_data == TERMINATE_CODE) begin
          eof_d   = 1'b1;
          state_d = IDLE;
          ok_d    = !(cnt_q < 11'(DATA_MIN) || pat_q);
          err_d   = !ok_d;
          code_d  = cnt_q < 11'(DATA_MIN) ? E_TOO_SHORT : pat_q ? E_PATTERN : 3'd0;
        end else begin
          err_d   = 1'b1;
          code_d  = E_BAD_CTRL;
          state_d = i_rx_data == IDLE_CODE ? IDLE : DROP;
        end
      end
      DROP: state_d = (is_ctl && (i_rx_data == TERMINATE_CODE || i_rx_data == IDLE_CODE)) ? IDLE : DROP;
    endcase
    // Frames failing before SFD have no payload, so they report a zero length.
    bcnt_d = (ok_d || err_d) ? (state_q == DATA ? cnt_q : '0) : bcnt_q;
    good_d = good_q + 16'(ok_d && good_q != 16'hFFFF);
    bad_d  = bad_q + 16'(err_d && bad_q != 16'hFFFF);
  end
  always_ff @(posedge tx_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
      bcnt_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
      bcnt_q  <= bcnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end
  assign o_data        = data_q;
  assign o_data_valid  = dv_q;
  assign o_sof         = sof_q;
  assign o_eof         = eof_q;
  assign o_frame_ok    = ok_q;
  assign o_frame_err   = err_q;
  assign o_err_code    = code_q;
  assign o_byte_count  = bcnt_q;
  assign o_good_frames = good_q;
  assign o_bad_frames  = bad_q;
endmodule

// File: doc/mii_frame_checker.md
Name: mii_frame_checker

Overview:
- Receive-side counterpart of the 8-bit MII/XGMII-style frame generator.
- Parses a byte stream of the form idle / optional start / preamble / SFD / data / terminate.
- Forwards payload bytes, checks framing and the payload pattern, and reports a per-frame result and saturating statistics.
- Sits at the loopback/check end of the TX path. Runs on the same clock as the generator.

Parameters:
- PREAMBLE_MIN, 6, minimum preamble bytes accepted before SFD
- PREAMBLE_MAX, 7, maximum preamble bytes accepted before SFD
- DATA_MIN, 46, minimum payload bytes for a good frame
- DATA_MAX, 1500, maximum payload bytes
- CHECK_PATTERN, 1, 1 = compare every payload byte against DATA_CHAR_PATTERN
- DATA_CHAR_PATTERN, 8'hAA, expected payload byte
- IDLE_CODE, 8'h07, idle control character
- START_CODE, 8'hFB, start control character
- PREAMBLE_CODE, 8'h55, preamble data byte
- SFD_CODE, 8'hD5, SFD data byte
- TERMINATE_CODE, 8'hFD, terminate control character

Ports:
- tx_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rx_data  in  8  received byte
- i_rx_ctrl  in  1  1 = i_rx_data is a control character, 0 = data byte
- o_data  out  8  payload byte
- o_data_valid  out  1  o_data is a payload byte
- o_sof  out  1  pulse with the first payload byte
- o_eof  out  1  pulse on a valid terminate in DATA
- o_frame_ok  out  1  pulse: frame passed all checks
- o_frame_err  out  1  pulse: frame failed
- o_err_code  out  3  error cause, valid with o_frame_err, held until next result
- o_byte_count  out  11  payload length of the last finished frame
- o_good_frames  out  16  saturating count of good frames
- o_bad_frames  out  16  saturating count of bad frames

Behaviour:
- All outputs are registered, with 1-cycle latency from the sampled input.
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset mid-frame aborts the frame and reports nothing.
- Error codes: 1 PRE_SHORT, 2 PRE_LONG, 3 BAD_PRE, 4 TOO_SHORT, 5 TOO_LONG, 6 PATTERN, 7 BAD_CTRL.
- States: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - ctrl=1 & START_CODE -> PREAMBLE, pre_cnt=0.
  - ctrl=0 & PREAMBLE_CODE -> PREAMBLE, pre_cnt=1.
  - Any other byte is ignored silently, with no error (covers post-reset 8'h00).
- PREAMBLE:
  - ctrl=0 & PREAMBLE_CODE: pre_cnt+1. If the result exceeds PREAMBLE_MAX -> err PRE_LONG, go to DROP.
  - ctrl=0 & SFD_CODE: if pre_cnt >= PREAMBLE_MIN -> DATA with byte_cnt=0; else err PRE_SHORT, go to DROP.
  - Anything else -> err BAD_PRE. Go to IDLE if ctrl=1 & IDLE_CODE, else DROP.
- DATA:
  - ctrl=0: o_data=byte and o_data_valid=1, byte_cnt+1. o_sof=1 when byte_cnt was 0.
  - If CHECK_PATTERN and byte != DATA_CHAR_PATTERN, set the per-frame sticky pat_err.
  - A data byte arriving with byte_cnt == DATA_MAX is not forwarded -> err TOO_LONG, go to DROP.
  - ctrl=1 & TERMINATE_CODE: o_eof=1, go to IDLE. Result, in priority order: byte_cnt < DATA_MIN -> TOO_SHORT; else pat_err -> PATTERN; else ok.
  - ctrl=1, any other character -> err BAD_CTRL, no o_eof. Go to IDLE if IDLE_CODE, else DROP.
- DROP: discard bytes until ctrl=1 & (TERMINATE_CODE or IDLE_CODE), then go to IDLE. No further result pulses.
- Result rules:
  - Each frame entering PREAMBLE produces exactly one o_frame_ok or o_frame_err pulse; the two are never high together.
  - o_byte_count and o_err_code update with that pulse. o_err_code is 0 on ok.
- Statistics counters increment with their result pulse and saturate at 16'hFFFF.
- pat_err and byte_cnt clear on entry to DATA.
- The payload length check uses byte_cnt exclusive of SFD and terminate.

Test Plan:
1. Idle, START, 7x55, D5, 46x AA, FD(ctrl) -> 46 o_data_valid, o_sof on first byte, o_frame_ok=1, o_byte_count=46, o_good_frames=1.
2. Same frame with payload byte 10 = 8'h00 -> o_frame_err, o_err_code=6, o_bad_frames=1, all 46 bytes forwarded.
3. 3x55 then D5 -> o_frame_err code 1; the following bytes up to the next idle produce no o_data_valid; a clean frame afterwards -> ok.
4. 20 payload bytes then FD -> code 4, o_byte_count=20. Next, 1501 payload bytes -> code 5 on byte 1501, exactly 1500 o_data_valid.
5. Terminate replaced by ctrl=1 07 mid-payload -> code 7, no o_eof, state IDLE, next frame accepted.
6. Assert i_rst during DATA -> all outputs 0 next edge, no result pulse; drive 2^16+2 good frames (force counter) -> o_good_frames holds 16'hFFFF.
